// File: rtl/wb_trace_checker_if.sv
// Debug write-back trace as presented by the CPU retire stage.
// The CPU side drives it through master; the checker samples it through slave.
interface wb_trace_checker_if;
  logic        wb_have_inst;
  logic [31:0] wb_pc;
  logic        wb_ena;
  logic [4:0]  wb_reg;
  logic [31:0] wb_value;

  modport master (output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value);
  modport slave  (input  wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value);
endinterface

// File: rtl/wb_trace_checker.sv
// Golden-trace checker: walks a combinational-read golden ROM in lockstep with retiring
// instructions. Define WB_CHECK_CONTINUE_EN to keep running (and counting) past mismatches.
module wb_trace_checker #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  wb_trace_checker_if.slave   wb,
  output logic [ADDR_W-1:0]   gold_addr,
  input  logic [70:0]         gold_data,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [ADDR_W-1:0]   err_idx,
  output logic [31:0]         err_pc,
  output logic [31:0]         err_value,
  output logic [31:0]         inst_count,
  output logic [15:0]         err_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;
  typedef enum logic [1:0] {FC_NONE = 2'd0, FC_MISMATCH = 2'd1,
                            FC_TIMEOUT = 2'd2, FC_OVERRUN = 2'd3} fail_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } gold_t;

  state_e            state_q, state_d;
  fail_e             fc_q, fc_d;
  logic [ADDR_W-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
  logic [31:0]       inst_cnt_q, inst_cnt_d, err_pc_q, err_pc_d, err_val_q, err_val_d;
  logic [15:0]       err_cnt_q, err_cnt_d, tmo_q, tmo_d;

  gold_t gold;
  logic  hit, running, restart, end_seen, retire, miss, expire;
  logic  advance, stop_miss, overrun;

  assign gold = gold_t'(gold_data);

  // x0 writes are value-don't-care; reg and value only matter when the entry writes.
  always_comb begin
    hit = (wb.wb_pc == gold.pc) && (wb.wb_ena == gold.ena);
    if (gold.ena && (wb.wb_reg != gold.rd))
      hit = 1'b0;
    if (gold.ena && (gold.rd != 5'd0) && (wb.wb_value != gold.value))
      hit = 1'b0;
  end

  // The end marker wins over any wb sample presented in the same cycle.
  always_comb begin
    running  = (state_q == S_RUN);
    restart  = start && !running;
    end_seen = running && !gold.valid;
    retire   = running && gold.valid && wb.wb_have_inst;
    miss     = retire && !hit;
    expire   = running && gold.valid && !wb.wb_have_inst &&
               (tmo_q == 16'(TIMEOUT - 1));
  end

`ifdef WB_CHECK_CONTINUE_EN
  assign advance   = retire;
  assign stop_miss = 1'b0;
`else
  assign advance   = retire && hit;
  assign stop_miss = miss;
`endif

  assign overrun = advance && (&idx_q);

  // NOTE: every register has a synchronous reset and is written with <= only, so all
  // flops update together from values computed in the combinational processes.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: each always_comb assigns defaults first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: if (restart) state_d = S_RUN;
      S_RUN: begin
        if (end_seen)                           state_d = (err_cnt_q == '0) ? S_PASS : S_FAIL;
        else if (overrun || expire || stop_miss) state_d = S_FAIL;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    unique case (state_q)
      S_RUN:  busy = 1'b1;
      S_PASS: begin done = 1'b1; pass = 1'b1; end
      S_FAIL: done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    inst_cnt_d = inst_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_idx_d  = err_idx_q;
    err_pc_d   = err_pc_q;
    err_val_d  = err_val_q;
    tmo_d      = tmo_q;
    fc_d       = fc_q;
    if (restart) begin
      idx_d      = '0;
      inst_cnt_d = '0;
      err_cnt_d  = '0;
      err_idx_d  = '0;
      err_pc_d   = '0;
      err_val_d  = '0;
      tmo_d      = '0;
      fc_d       = FC_NONE;
    end else if (end_seen) begin
      fc_d = (err_cnt_q == '0) ? FC_NONE : FC_MISMATCH;
    end else if (retire) begin
      tmo_d = '0;
      if (advance) idx_d = idx_q + ADDR_W'(1);
      if (hit)     inst_cnt_d = inst_cnt_q + 32'd1;
      // Error details describe the first failure only.
      if ((miss || overrun) && (err_cnt_q == '0)) begin
        err_idx_d = idx_q;
        err_pc_d  = wb.wb_pc;
        err_val_d = wb.wb_value;
      end
      if (miss && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      if (overrun)        fc_d = FC_OVERRUN;
      else if (stop_miss) fc_d = FC_MISMATCH;
    end else if (running) begin
      tmo_d = tmo_q + 16'd1;
      if (expire) begin
        fc_d = FC_TIMEOUT;
        if (err_cnt_q == '0) err_idx_d = idx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      inst_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_idx_q  <= '0;
      err_pc_q   <= '0;
      err_val_q  <= '0;
      tmo_q      <= '0;
      fc_q       <= FC_NONE;
    end else begin
      idx_q      <= idx_d;
      inst_cnt_q <= inst_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_idx_q  <= err_idx_d;
      err_pc_q   <= err_pc_d;
      err_val_q  <= err_val_d;
      tmo_q      <= tmo_d;
      fc_q       <= fc_d;
    end
  end

  assign gold_addr  = idx_q;
  assign fail_code  = fc_q;
  assign err_idx    = err_idx_q;
  assign err_pc     = err_pc_q;
  assign err_value  = err_val_q;
  assign inst_count = inst_cnt_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Scoreboard bench for wb_trace_checker: a trace-level model predicts each run's outcome,
// and a monitor compares it when done rises.
`timescale 1ns/1ps
module tb_wb_trace_checker;
  localparam int ADDR_W  = 3;
  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 1 << ADDR_W;
`ifdef WB_CHECK_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } entry_t;

  typedef struct {
    bit          have;
    logic [31:0] pc;
    bit          ena;
    logic [4:0]  rd;
    logic [31:0] value;
  } item_t;

  typedef struct {
    int          id;
    bit          pass;
    int          code;
    bit          detail;
    int          gaddr;
    int          err_idx;
    logic [31:0] err_pc;
    logic [31:0] err_value;
    int          inst;
    int          errs;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start;
  logic [ADDR_W-1:0] gold_addr, err_idx;
  logic [70:0] gold_data;
  logic busy, done, pass;
  logic [1:0] fail_code;
  logic [31:0] err_pc, err_value, inst_count;
  logic [15:0] err_count;

  wb_trace_checker_if wb ();

  logic [70:0] gold_mem [DEPTH];
  entry_t      gold_q   [DEPTH];
  assign gold_data = gold_mem[gold_addr];

  wb_trace_checker #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .wb(wb.slave),
    .gold_addr(gold_addr), .gold_data(gold_data),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .err_idx(err_idx), .err_pc(err_pc), .err_value(err_value),
    .inst_count(inst_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0, failures = 0;
  int   start_cyc = 0;
  exp_t exp_q[$];
  bit   mon_done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_gold(input int i, input bit v, input logic [31:0] pc, input bit ena,
                          input logic [4:0] rd, input logic [31:0] value);
    gold_mem[i]       = {v, pc, ena, rd, value};
    gold_q[i].valid   = v;
    gold_q[i].pc      = pc;
    gold_q[i].ena     = ena;
    gold_q[i].rd      = rd;
    gold_q[i].value   = value;
  endtask

  task automatic clear_gold();
    for (int i = 0; i < DEPTH; i++) set_gold(i, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic load_gold3();
    clear_gold();
    set_gold(0, 1'b1, 32'h0, 1'b1, 5'd1, 32'd5);
    set_gold(1, 1'b1, 32'h4, 1'b1, 5'd2, 32'd6);
    set_gold(2, 1'b1, 32'h8, 1'b1, 5'd3, 32'd7);
  endtask

  function automatic item_t ret(input entry_t g);
    item_t it;
    it.have = 1'b1; it.pc = g.pc; it.ena = g.ena; it.rd = g.rd; it.value = g.value;
    return it;
  endfunction

  function automatic item_t idle_item();
    item_t it;
    it.have = 1'b0; it.pc = '0; it.ena = 1'b0; it.rd = '0; it.value = '0;
    return it;
  endfunction

  task automatic drive(input item_t it);
    wb.wb_have_inst = it.have;
    wb.wb_pc        = it.pc;
    wb.wb_ena       = it.ena;
    wb.wb_reg       = it.rd;
    wb.wb_value     = it.value;
  endtask

  function automatic bit entry_match(input entry_t g, input item_t w);
    if (w.pc != g.pc || w.ena != g.ena) return 1'b0;
    if (g.ena && w.rd != g.rd) return 1'b0;
    if (g.ena && g.rd != 5'd0 && w.value != g.value) return 1'b0;
    return 1'b1;
  endfunction

  // Walks the golden trace one cycle at a time; lat counts cycles from the start edge
  // to the edge at which the outcome becomes visible.
  function automatic exp_t predict(input item_t stim[$]);
    exp_t  e;
    int    idx, idle;
    bit    ok;
    item_t it;
    e.id = 0; e.pass = 1'b0; e.code = 0; e.detail = 1'b1; e.gaddr = 0; e.err_idx = 0;
    e.err_pc = '0; e.err_value = '0; e.inst = 0; e.errs = 0; e.lat = 0;
    idx = 0; idle = 0;
    for (int k = 0; k < 1000; k++) begin
      e.lat = k + 1;
      if (!gold_q[idx].valid) begin
        e.pass = (e.errs == 0); e.code = (e.errs == 0) ? 0 : 1; e.gaddr = idx;
        return e;
      end
      it = (k < stim.size()) ? stim[k] : idle_item();
      if (it.have) begin
        idle = 0;
        ok = entry_match(gold_q[idx], it);
        if (ok) e.inst++;
        else begin
          if (e.errs == 0) begin e.err_idx = idx; e.err_pc = it.pc; e.err_value = it.value; end
          e.errs++;
          if (!CONT) begin e.code = 1; e.gaddr = idx; return e; end
        end
        if (idx == DEPTH - 1) begin e.code = 3; e.detail = 1'b0; return e; end
        idx++;
      end else begin
        idle++;
        if (idle == TIMEOUT) begin
          e.code = 2; e.gaddr = idx;
          if (e.errs == 0) e.err_idx = idx;
          return e;
        end
      end
    end
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !mon_done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          e = exp_q.pop_front();
          check($sformatf("s%0d_pass", e.id),       pass,       32'(e.pass));
          check($sformatf("s%0d_fail_code", e.id),  fail_code,  32'(e.code));
          check($sformatf("s%0d_inst_count", e.id), inst_count, 32'(e.inst));
          check($sformatf("s%0d_err_count", e.id),  err_count,  32'(e.errs));
          check($sformatf("s%0d_latency", e.id),    32'(cyc - start_cyc), 32'(e.lat));
          if (e.detail) begin
            check($sformatf("s%0d_gold_addr", e.id), gold_addr, 32'(e.gaddr));
            check($sformatf("s%0d_err_idx", e.id),   err_idx,   32'(e.err_idx));
            check($sformatf("s%0d_err_pc", e.id),    err_pc,    e.err_pc);
            check($sformatf("s%0d_err_value", e.id), err_value, e.err_value);
          end
        end
      end
      mon_done_prev = done;
    end
  end

  task automatic do_start(input int id);
    @(negedge clk);
    start = 1'b1;
    drive(idle_item());
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    check($sformatf("s%0d_start_busy", id),  busy,       32'd1);
    check($sformatf("s%0d_start_addr", id),  gold_addr,  32'd0);
    check($sformatf("s%0d_start_count", id), inst_count, 32'd0);
  endtask

  task automatic run_scenario(input item_t stim[$], input int id);
    exp_t e;
    int   waited;
    e    = predict(stim);
    e.id = id;
    exp_q.push_back(e);
    do_start(id);
    for (int k = 0; k < stim.size(); k++) begin
      drive(stim[k]);
      @(negedge clk);
    end
    drive(idle_item());
    waited = 0;
    while (exp_q.size() != 0 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL s%0d_no_done: got done=0 after %0d cycles expected completion", id, waited);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic random_scenario(input int id);
    item_t stim[$];
    item_t it;
    int    n, upto;
    n = $urandom_range(1, DEPTH - 1);
    clear_gold();
    for (int i = 0; i < n; i++)
      set_gold(i, 1'b1, 32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    upto = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : n;
    for (int i = 0; i < upto; i++) begin
      repeat ($urandom_range(0, 3)) stim.push_back(idle_item());
      it = ret(gold_q[i]);
      if (!gold_q[i].ena) begin
        it.rd = 5'($urandom); it.value = $urandom;
      end else if (gold_q[i].rd == 5'd0) begin
        it.value = $urandom;
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       it.pc    = it.pc ^ 32'h4;
          1:       it.ena   = ~it.ena;
          2:       it.rd    = it.rd ^ 5'($urandom_range(1, 31));
          default: it.value = it.value ^ (32'h1 << $urandom_range(0, 31));
        endcase
      end
      stim.push_back(it);
    end
    run_scenario(stim, id);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    item_t s[$];
    item_t it;
    rst   = 1'b1;
    start = 1'b0;
    drive(idle_item());
    clear_gold();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy",      busy,       32'd0);
    check("reset_done",      done,       32'd0);
    check("reset_pass",      pass,       32'd0);
    check("reset_fail_code", fail_code,  32'd0);
    check("reset_gold_addr", gold_addr,  32'd0);
    check("reset_inst",      inst_count, 32'd0);
    check("reset_err_count", err_count,  32'd0);
    check("reset_err_pc",    err_pc,     32'd0);

    // Clean three-entry trace.
    load_gold3();
    s = {ret(gold_q[0]), ret(gold_q[1]), ret(gold_q[2])};
    run_scenario(s, 1);

    // Second retire carries a wrong value.
    it = ret(gold_q[1]); it.value = 32'h9;
    s = {ret(gold_q[0]), it, ret(gold_q[2])};
    run_scenario(s, 2);

    // x0 write: value is don't-care, but the register still has to match.
    clear_gold();
    set_gold(0, 1'b1, 32'h40, 1'b1, 5'd0, 32'h1234);
    it = ret(gold_q[0]); it.value = 32'hDEAD;
    s = {it};
    run_scenario(s, 3);
    it.rd = 5'd5;
    s = {it};
    run_scenario(s, 4);

    // One retire, then silence until the timeout fires.
    load_gold3();
    s = {ret(gold_q[0])};
    run_scenario(s, 5);

    // Synchronous reset in the middle of a run.
    do_start(6);
    drive(ret(gold_q[0]));
    @(negedge clk);
    drive(ret(gold_q[1]));
    @(negedge clk);
    check("midrun_gold_addr", gold_addr, 32'd2);
    check("midrun_busy",      busy,      32'd1);
    rst = 1'b1;
    drive(idle_item());
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      busy,       32'd0);
    check("abort_done",      done,       32'd0);
    check("abort_gold_addr", gold_addr,  32'd0);
    check("abort_inst",      inst_count, 32'd0);
    check("abort_fail_code", fail_code,  32'd0);
    s = {ret(gold_q[0]), ret(gold_q[1]), ret(gold_q[2])};
    run_scenario(s, 7);

    // Every entry valid and matched: the index runs off the end.
    clear_gold();
    for (int i = 0; i < DEPTH; i++)
      set_gold(i, 1'b1, 32'h200 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(100 + i));
    s = {};
    for (int i = 0; i < DEPTH; i++) s.push_back(ret(gold_q[i]));
    run_scenario(s, 8);

    // Restart straight from FAIL, then randomized traces.
    for (int r = 0; r < 40; r++) random_scenario(100 + r);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_checker.md
Name: wb_trace_checker

Overview:
- Consumer end of the CPU's debug write-back trace (debug_wb_have_inst/pc/ena/reg/value).
- Steps a golden-trace memory in lockstep with retiring instructions and compares every retired instruction against the golden entry.
- Reports pass, mismatch or timeout, and captures details of the first failure.
- Sits beside the CPU top in simulation and FPGA self-test builds; the golden memory uses the same combinational-read ROM style as inst_mem (address in, data out the same cycle).

Parameters:
- ADDR_W, 14, golden-trace address width (depth 2^ADDR_W entries).
- TIMEOUT, 1024, consecutive RUN cycles without a retired instruction before a timeout failure; range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse: begin checking from golden index 0
- wb_have_inst  input  1  retired-instruction valid (from debug_wb_have_inst)
- wb_pc  input  32  retired PC
- wb_ena  input  1  register-write enable
- wb_reg  input  5  destination register
- wb_value  input  32  write-back value
- gold_addr  output  ADDR_W  golden memory index
- gold_data  input  71  golden entry, combinational: {valid[70], pc[69:38], ena[37], reg[36:32], value[31:0]}
- busy  output  1  high in RUN
- done  output  1  high in PASS or FAIL
- pass  output  1  high in PASS only
- fail_code  output  2  0 none, 1 mismatch, 2 timeout, 3 overrun (index wrapped)
- err_idx  output  ADDR_W  golden index of first failure
- err_pc  output  32  wb_pc at first failure
- err_value  output  32  wb_value at first failure
- inst_count  output  32  instructions matched since start, wraps at 2^32
- err_count  output  16  mismatches counted, saturating

Behaviour:
- Decided interface: single clock clk; reset rst is synchronous, active-high.
- Reset:
  - state=IDLE.
  - gold_addr, inst_count, err_count, err_idx, err_pc and err_value all 0.
  - busy=done=pass=0, fail_code=0.
  - Timeout counter 0.
  - rst asserted mid-RUN aborts immediately to this state; it has priority over every other event.
- States: IDLE, RUN, PASS, FAIL; outputs are decoded from registered state.
  - IDLE: on start, go to RUN; clear gold_addr, counters and error fields.
  - RUN, each cycle:
    - If gold_data.valid==0, go to PASS when err_count==0, otherwise FAIL with code 1. The end marker is checked before any wb sample in the same cycle; that sample is ignored.
    - Else if wb_have_inst, compare, then either increment gold_addr and inst_count, or record a mismatch. Clear the timeout counter.
    - Else increment the timeout counter; at TIMEOUT go to FAIL with code 2 and err_idx=gold_addr.
  - Compare rule, all must hold:
    - wb_pc==gold.pc and wb_ena==gold.ena.
    - If gold.ena, wb_reg==gold.reg.
    - If gold.ena and gold.reg!=0, wb_value==gold.value (x0 writes are value-don't-care).
  - Mismatch:
    - First mismatch latches err_idx=gold_addr, err_pc=wb_pc, err_value=wb_value.
    - err_count increments, saturating at 16'hFFFF.
    - Default build: next state FAIL with fail_code=1.
  - Latency: a sample in cycle N is reflected in registered outputs (gold_addr, done, fail_code) at cycle N+1.
  - Overrun: a match at gold_addr==all-ones, with no end marker reached, goes to FAIL with code 3.
  - PASS/FAIL: outputs hold. start restarts exactly as from IDLE. wb_* inputs are ignored.
- start while in RUN is ignored.
- gold_addr is driven straight from the index register.

Optional Feature:
- Macro: WB_CHECK_CONTINUE_EN.
- Defined:
  - A mismatch does not stop the run; gold_addr still advances.
  - err_* fields hold the first mismatch only; err_count accumulates every mismatch.
  - The end marker then resolves to PASS or FAIL(1) per the RUN rule.
- Undefined:
  - The first mismatch goes to FAIL.
  - err_count never exceeds 1.
  - The continue logic is not compiled in.

Test Plan:
- Golden 3 entries (pc 0x0,0x4,0x8; ena=1; reg 1,2,3; values 5,6,7) then valid=0; matching wb stream with have_inst=1 every cycle after start → PASS the cycle after end marker is seen, pass=1, inst_count=3, fail_code=0.
- Same golden, second retire wb_value=0x9 → FAIL, fail_code=1, err_idx=1, err_pc=0x4, err_value=0x9, inst_count=1. With WB_CHECK_CONTINUE_EN instead: run reaches end marker, FAIL code 1, err_count=1, gold_addr=3.
- Golden entry ena=1 reg=0 value=0x1234; wb value 0xDEAD → match, counted; same entry but wb_reg=5 → mismatch.
- TIMEOUT=8; start, one matched inst, then have_inst=0 held → FAIL code 2 exactly 8 cycles after last retire, err_idx=1.
- Assert rst for one cycle mid-RUN at gold_addr=2 → next cycle IDLE, all outputs 0; subsequent start checks from index 0.
- ADDR_W=2, four valid matching entries with no end marker → FAIL code 3 after fourth match; start in FAIL restarts with gold_addr=0, inst_count=0.
